// File: rtl/dmem_responder.sv
// Data-memory responder: single outstanding load/store with a fixed number of
// wait states, byte-lane stores, sign/zero-extended loads and fault reporting.
module dmem_responder #(
    parameter int DEPTH_WORDS = 128,
    parameter int WAIT_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        MemRead,
    input  logic        MemWrite,
    input  logic [2:0]  Funct3,
    input  logic [31:0] Addr,
    input  logic [31:0] WrData,
    output logic [31:0] RdData,
    output logic        Stall,
    output logic        Ready,
    output logic        Error
);

    localparam int IDX_W = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state, state_next;
    logic [3:0]       cnt, cnt_next;
    logic             req, accept;

    logic [IDX_W-1:0] idx_p0;
    logic [1:0]       off_p0;
    logic [2:0]       f3_p0;
    logic [31:0]      wdata_p0;
    logic             write_p0;
    logic             fault_p0;

    logic [31:0]      mem [DEPTH_WORDS];
    logic [31:0]      word_rd;
    logic [3:0]       lanes;
    logic [31:0]      wdata_aligned;

    function automatic logic access_fault(input logic rd, input logic wr,
                                          input logic [2:0] f3, input logic [31:0] a);
        logic range_f, align_f, type_f;
        range_f = |a[31:IDX_W+2];
        align_f = (f3[1:0] == 2'b01 && a[0]) || (f3[1:0] == 2'b10 && a[1:0] != 2'b00);
        if (wr)
            type_f = f3[2] | (f3[1] & f3[0]);
        else
            type_f = (f3[1] & f3[0]) | (f3[2] & f3[1]);
        return (rd && wr) || range_f || align_f || type_f;
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word,
                                                input logic [2:0] f3, input logic [1:0] off);
        logic [31:0]        shifted;
        logic signed [7:0]  b;
        logic signed [15:0] h;
        shifted = word >> {off, 3'b000};
        b = shifted[7:0];
        h = shifted[15:0];
        case (f3)
            3'b000:  return {{24{b[7]}}, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b010:  return word;
            3'b100:  return {24'd0, shifted[7:0]};
            3'b101:  return {16'd0, shifted[15:0]};
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [3:0] store_lanes(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            3'b000:  return 4'b0001 << off;
            3'b001:  return 4'b0011 << off;
            3'b010:  return 4'b1111;
            default: return 4'b0000;
        endcase
    endfunction

    assign req    = MemRead | MemWrite;
    assign accept = (state == IDLE) && req;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        case (state)
            IDLE: begin
                if (req) begin
                    if (WAIT_LOAD == 4'd0) begin
                        state_next = RESP;
                    end else begin
                        state_next = WAIT;
                        cnt_next   = WAIT_LOAD;
                    end
                end
            end
            WAIT: begin
                cnt_next = cnt - 4'd1;
                if (cnt == 4'd1)
                    state_next = RESP;
            end
            RESP:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // capture stage: access attributes are frozen at the accepting edge
    always_ff @(posedge clk) begin
        if (accept) begin
            idx_p0   <= Addr[IDX_W+1:2];
            off_p0   <= Addr[1:0];
            f3_p0    <= Funct3;
            wdata_p0 <= WrData;
            write_p0 <= MemWrite;
            fault_p0 <= access_fault(MemRead, MemWrite, Funct3, Addr);
        end
    end

    assign lanes         = store_lanes(f3_p0, off_p0);
    assign wdata_aligned = wdata_p0 << {off_p0, 3'b000};

    // response stage: stores commit on the edge that leaves RESP
    always_ff @(posedge clk) begin
        if (state == RESP && write_p0 && !fault_p0) begin
            for (int i = 0; i < 4; i++) begin
                if (lanes[i])
                    mem[idx_p0][8*i +: 8] <= wdata_aligned[8*i +: 8];
            end
        end
    end

    assign word_rd = mem[idx_p0];

    always_comb begin
        RdData = 32'd0;
        if (state == RESP && !write_p0 && !fault_p0)
            RdData = load_extend(word_rd, f3_p0, off_p0);
    end

    // rst_n gates Stall so a request held during reset does not stall the pipe
    assign Stall = rst_n && (accept || state == WAIT);
    assign Ready = (state == RESP);
    assign Error = (state == RESP) && fault_p0;

endmodule

// File: tb/tb_dmem_responder.sv
// Bench for dmem_responder: directed spec scenarios, random accesses against a
// word-array reference model, reset abort, and a zero-wait-state instance.
module tb_dmem_responder;

    localparam int DEPTH  = 128;
    localparam int W      = 2;
    localparam int DEPTH0 = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_read, mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr, wr_data, rd_data;
    logic        stall, ready, error;

    logic        mem_read0, mem_write0;
    logic [2:0]  funct30;
    logic [31:0] addr0, wr_data0, rd_data0;
    logic        stall0, ready0, error0;

    int tests = 0;
    int fails = 0;
    logic [31:0] model [DEPTH];

    always #5 clk = ~clk;

    dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst_n(rst_n), .MemRead(mem_read), .MemWrite(mem_write),
        .Funct3(funct3), .Addr(addr), .WrData(wr_data), .RdData(rd_data),
        .Stall(stall), .Ready(ready), .Error(error)
    );

    dmem_responder #(.DEPTH_WORDS(DEPTH0), .WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .MemRead(mem_read0), .MemWrite(mem_write0),
        .Funct3(funct30), .Addr(addr0), .WrData(wr_data0), .RdData(rd_data0),
        .Stall(stall0), .Ready(ready0), .Error(error0)
    );

    initial begin
        #1000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic bit exp_fault(input bit rd, input bit wr, input int f3, input logic [31:0] a);
        int size;
        bit bad_type;
        if (rd && wr) return 1;
        if (a / 4 >= DEPTH) return 1;
        bad_type = rd ? (f3 == 3 || f3 == 6 || f3 == 7) : (f3 > 2);
        if (bad_type) return 1;
        size = (f3 % 4 == 0) ? 1 : (f3 % 4 == 1) ? 2 : 4;
        return (a % size) != 0;
    endfunction

    function automatic logic [31:0] ld_result(input logic [31:0] w, input int f3, input logic [31:0] a);
        logic [31:0] b, h;
        b = (w >> (8 * (a % 4))) & 32'hFF;
        h = (w >> (8 * (a % 4))) & 32'hFFFF;
        case (f3)
            0:       return (b >= 128) ? b - 32'd256 : b;
            1:       return (h >= 32768) ? h - 32'd65536 : h;
            2:       return w;
            4:       return b;
            5:       return h;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [31:0] st_merge(input logic [31:0] w, input logic [31:0] d,
                                             input int f3, input logic [31:0] a);
        logic [31:0] mask;
        mask = (f3 == 0) ? 32'hFF : (f3 == 1) ? 32'hFFFF : 32'hFFFF_FFFF;
        mask = mask << (8 * (a % 4));
        return (w & ~mask) | ((d << (8 * (a % 4))) & mask);
    endfunction

    task automatic access(input bit rd, input bit wr, input int f3, input logic [31:0] a,
                          input logic [31:0] wd);
        bit flt, seen;
        int idx;
        logic [31:0] exp_rd;
        flt    = exp_fault(rd, wr, f3, a);
        idx    = int'(a / 4) % DEPTH;
        exp_rd = (!flt && rd) ? ld_result(model[idx], f3, a) : 32'd0;
        @(posedge clk); #1;
        mem_read = rd; mem_write = wr; funct3 = 3'(f3); addr = a; wr_data = wd;
        @(negedge clk);
        chk("stall_c0", stall, 1);
        chk("ready_c0", ready, 0);
        seen = 0;
        for (int c = 1; c <= 20 && !seen; c++) begin
            @(posedge clk); #1;
            if (c == 1) begin
                mem_read = 0; mem_write = 0;
                funct3 = 3'($urandom); addr = $urandom; wr_data = $urandom;
            end
            @(negedge clk);
            if (ready) begin
                seen = 1;
                chk("latency", c, W + 1);
                chk("error", error, flt);
                chk("rddata", rd_data, exp_rd);
                chk("stall_resp", stall, 0);
            end else begin
                chk("stall_wait", stall, 1);
                chk("rddata_wait", rd_data, 0);
            end
        end
        chk("ready_seen", 32'(seen), 1);
        if (!flt && wr) model[idx] = st_merge(model[idx], wd, f3, a);
    endtask

    initial begin
        rst_n = 0;
        mem_read = 1; mem_write = 0; funct3 = 3'd2; addr = 32'h0; wr_data = 32'h0;
        mem_read0 = 0; mem_write0 = 0; funct30 = 3'd0; addr0 = 32'h0; wr_data0 = 32'h0;
        repeat (2) @(negedge clk);
        chk("rst_stall", stall, 0);
        chk("rst_ready", ready, 0);
        chk("rst_error", error, 0);
        chk("rst_rddata", rd_data, 0);

        // request already present as reset releases: accepted at first edge
        rst_n = 1;
        @(posedge clk); #1;
        mem_read = 0;
        @(negedge clk); chk("first_wait1", stall, 1);
        @(negedge clk); chk("first_wait2", stall, 1);
        @(negedge clk); chk("first_ready", ready, 1);
        chk("first_error", error, 0);

        for (int i = 0; i < DEPTH; i++) access(0, 1, 2, 32'(i * 4), $urandom);

        access(0, 1, 2, 32'h10, 32'hDEADBEEF);
        access(1, 0, 2, 32'h10, 32'h0);
        access(0, 1, 0, 32'h11, 32'h000000A5);
        access(1, 0, 0, 32'h11, 32'h0);
        access(1, 0, 4, 32'h11, 32'h0);
        access(1, 0, 2, 32'h10, 32'h0);
        access(1, 0, 1, 32'h12, 32'h0);
        access(1, 0, 5, 32'h12, 32'h0);
        access(1, 0, 2, 32'h12, 32'h0);
        access(0, 1, 1, 32'h13, 32'h5555AAAA);
        access(1, 0, 2, 32'h10, 32'h0);
        access(0, 1, 2, 32'(4 * DEPTH), 32'h11111111);
        access(1, 1, 2, 32'h10, 32'h22222222);
        access(1, 0, 2, 32'h10, 32'h0);
        chk("model_word10", model[4], 32'hDEADA5EF);

        // reset pulse during WAIT aborts the store
        @(posedge clk); #1;
        mem_write = 1; funct3 = 3'd2; addr = 32'h20; wr_data = 32'h12345678;
        @(posedge clk); #1;
        mem_write = 0;
        #2 rst_n = 0;
        #1;
        chk("abort_stall", stall, 0);
        chk("abort_ready", ready, 0);
        chk("abort_error", error, 0);
        chk("abort_rddata", rd_data, 0);
        @(negedge clk);
        rst_n = 1;
        access(1, 0, 2, 32'h20, 32'h0);

        for (int n = 0; n < 80; n++) begin
            int kind, f3;
            logic [31:0] a;
            kind = $urandom_range(0, 9);
            f3   = $urandom_range(0, 7);
            a    = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, DEPTH * 4 - 1));
            access(kind <= 4 || kind == 9, kind >= 5, f3, a, $urandom);
        end

        // zero-wait-state instance: two stores, then a held read request
        @(posedge clk); #1;
        mem_write0 = 1; funct30 = 3'd2; addr0 = 32'h0; wr_data0 = 32'h0BADF00D;
        @(posedge clk); #1;
        mem_write0 = 0;
        @(negedge clk); chk("w0_ready_st", ready0, 1);
        @(posedge clk); #1;
        mem_write0 = 1; addr0 = 32'h4; wr_data0 = 32'hC0FFEE11;
        @(posedge clk); #1;
        mem_write0 = 0;
        @(posedge clk); #1;
        mem_read0 = 1; funct30 = 3'd2; addr0 = 32'h0;
        @(negedge clk);
        chk("w0_c0_stall", stall0, 1);
        chk("w0_c0_ready", ready0, 0);
        @(posedge clk); #1;
        addr0 = 32'h4;
        @(negedge clk);
        chk("w0_c1_ready", ready0, 1);
        chk("w0_c1_stall", stall0, 0);
        chk("w0_c1_rddata", rd_data0, 32'h0BADF00D);
        @(negedge clk);
        chk("w0_c2_ready", ready0, 0);
        chk("w0_c2_stall", stall0, 1);
        @(posedge clk); #1;
        mem_read0 = 0;
        @(negedge clk);
        chk("w0_c3_ready", ready0, 1);
        chk("w0_c3_rddata", rd_data0, 32'hC0FFEE11);
        chk("w0_c3_error", error0, 0);
        @(negedge clk);
        chk("w0_c4_ready", ready0, 0);
        chk("w0_c4_stall", stall0, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/dmem_responder.md
DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 Parameter DEPTH_WORDS, default 128: number of 32-bit words of storage; power of two, at least 4.
REQ-002 Parameter WAIT_CYCLES, default 2: wait states per access; range 0..15.
REQ-003 clk  in  1  sole clock; all state updates on its rising edge.
REQ-004 rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 MemRead  in  1  load request from the decode control path.
REQ-006 MemWrite  in  1  store request from the decode control path.
REQ-007 Funct3  in  3  access type: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU for loads; 000 SB, 001 SH, 010 SW for stores.
REQ-008 Addr  in  32  byte address.
REQ-009 WrData  in  32  store data, right-aligned.
REQ-010 RdData  out  32  load result, extended per Funct3.
REQ-011 Stall  out  1  hold-pipeline indication.
REQ-012 Ready  out  1  one-cycle access-complete pulse.
REQ-013 Error  out  1  access fault, valid only while Ready=1.

Function
REQ-014 The FSM SHALL have exactly three states: IDLE, WAIT and RESP.
REQ-015 A request SHALL be MemRead=1 or MemWrite=1 while in IDLE; Addr, Funct3, WrData and the request type SHALL be captured at that edge.
REQ-016 Stall SHALL be 1 combinationally while a request is present in IDLE, and SHALL be 1 throughout WAIT; Stall SHALL be 0 in RESP and in IDLE with no request.
REQ-017 IDLE with a request SHALL go to WAIT with the counter loaded to WAIT_CYCLES; if WAIT_CYCLES=0 it SHALL go directly to RESP.
REQ-018 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 1.
REQ-019 RESP SHALL last one cycle with Ready=1 and then return to IDLE unconditionally.
REQ-020 Inputs present during the RESP cycle SHALL NOT start a new request.
REQ-021 Latency SHALL be fixed: a request first seen at cycle 0 SHALL give Ready=1 at cycle WAIT_CYCLES+1.
REQ-022 A store SHALL update memory at the RESP edge, writing only the addressed byte lanes (SB: 1 lane, SH: 2 lanes, SW: 4 lanes), little-endian.
REQ-023 In RESP, RdData SHALL show the load result: LB/LH sign-extended, LBU/LHU zero-extended, LW the full word. RdData SHALL be 0 outside RESP and for stores.
REQ-024 Error SHALL be raised for each of these faults:
- word index Addr[31:2] >= DEPTH_WORDS;
- misalignment: LH/LHU/SH with Addr[0]=1, or LW/SW with Addr[1:0]!=00;
- Funct3 of 011, 110 or 111 on a load, or not in {000,001,010} on a store;
- MemRead=1 and MemWrite=1 together.
REQ-025 On any faulted access, memory SHALL NOT be written, RdData SHALL be 0, and the access SHALL take the normal latency.
REQ-026 A load in RESP from the word stored in that same RESP cycle cannot occur, because there is a single outstanding access.

Reset
REQ-027 While rst_n=0: state IDLE, counter 0, and RdData=0, Stall=0, Ready=0, Error=0.
REQ-028 Memory contents SHALL NOT be reset.
REQ-029 Reset during WAIT or RESP SHALL abort the access with no memory write.
REQ-030 The first request SHALL be accepted on the first rising edge after rst_n deasserts.

Verification
REQ-031 SW Addr=0x10 WrData=0xDEADBEEF, then LW 0x10 -> each access Ready at cycle 3 with Stall=1 in cycles 0-2; the load returns RdData=0xDEADBEEF and Error=0.
REQ-032 SB 0x11 WrData=0x000000A5 over the word 0xDEADBEEF, then LB 0x11 and LBU 0x11 -> word becomes 0xDEADA5EF; LB returns 0xFFFFFFA5, LBU returns 0x000000A5.
REQ-033 LW 0x12, then SH 0x13 -> both give Ready with Error=1 and RdData=0, and memory is unchanged.
REQ-034 SW Addr=4*DEPTH_WORDS, then MemRead=MemWrite=1 -> both give Error=1 and no word in memory changes.
REQ-035 rst_n pulsed low during WAIT of SW 0x20 WrData=0x12345678 -> outputs go to 0 immediately; a later LW 0x20 returns the prior contents.
REQ-036 WAIT_CYCLES=0 build, back-to-back LW requests -> Ready at cycle 1 for each; a request seen during RESP is accepted only at the following IDLE cycle.
